// File: rtl/aesl_deadlock_pkg.sv
// Shared types and helpers for the per-kernel deadlock stall detector.
package aesl_deadlock_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SUSPECT = 2'd1,
        BLOCKED = 2'd2
    } dl_state_t;

    // Index width for an n-wide vector, never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/aesl_deadlock_prio_enc.sv
// Combinational priority encoder: reports the lowest set bit of vec and whether any bit is set.
module aesl_deadlock_prio_enc
    import aesl_deadlock_pkg::*;
#(
    parameter int unsigned N = 2
) (
    input  logic [N-1:0]          vec,
    output logic [idx_w(N)-1:0]   idx,
    output logic                  vld
);

    localparam int unsigned IW = idx_w(N);

    // Scan from the top so the lowest set bit is the last assignment.
    always_comb begin
        idx = '0;
        vld = |vec;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/aesl_deadlock_stall_detector.sv
// Per-kernel deadlock detector: flags a sticky block once the stall pattern stops changing
// for STALL_CYCLES consecutive cycles and snapshots the pattern seen at detection.
module aesl_deadlock_stall_detector
    import aesl_deadlock_pkg::*;
#(
    parameter int unsigned N_AXIS       = 2,
    parameter int unsigned N_INST       = 1,
    parameter int unsigned STALL_CYCLES = 1000,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [N_AXIS-1:0]           axis_block_sigs,
    input  logic [N_INST-1:0]           inst_idle_sigs,
    input  logic [N_INST-1:0]           inst_block_sigs,
    input  logic                        clear,
    output logic                        block,
    output logic [CNT_W-1:0]            stall_cnt,
    output logic [N_AXIS-1:0]           axis_snap,
    output logic [N_INST-1:0]           inst_snap,
    output logic [idx_w(N_AXIS)-1:0]    first_axis_idx,
    output logic                        first_axis_vld
);

    localparam int unsigned       SIG_W     = N_AXIS + N_INST;
    localparam int unsigned       IDX_W     = idx_w(N_AXIS);
    localparam longint unsigned   CNT_CAP   = (64'd1 << CNT_W) - 64'd1;
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]  STALL_LIM = CNT_W'(STALL_CYCLES);

    if (CNT_CAP < 64'(STALL_CYCLES)) begin : g_cnt_w_check
        $error("CNT_W too narrow to count to STALL_CYCLES");
    end

    dl_state_t            state_q, state_d;
    logic [SIG_W-1:0]     sig, prev_sig_q, prev_sig_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_inc;
    logic                 block_q, block_d;
    logic [N_AXIS-1:0]    axis_snap_q, axis_snap_d;
    logic [N_INST-1:0]    inst_snap_q, inst_snap_d;
    logic [IDX_W-1:0]     idx_q, idx_d, enc_idx;
    logic                 vld_q, vld_d, enc_vld;
    logic                 all_idle, stall_now, same_sig, enter_blocked;

    // A fully idle kernel has finished rather than deadlocked.
    assign sig       = {inst_block_sigs, axis_block_sigs};
    assign all_idle  = &inst_idle_sigs;
    assign stall_now = (|sig) & ~all_idle;
    assign same_sig  = (sig == prev_sig_q);
    assign cnt_inc   = cnt_q + CNT_W'(1);

    aesl_deadlock_prio_enc #(
        .N (N_AXIS)
    ) u_prio_enc (
        .vec (axis_block_sigs),
        .idx (enc_idx),
        .vld (enc_vld)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = RUN;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (stall_now) begin
                        state_d = (STALL_CYCLES == 1) ? BLOCKED : SUSPECT;
                    end
                end
                SUSPECT: begin
                    if (!stall_now) begin
                        state_d = RUN;
                    end else if (same_sig && (cnt_inc == STALL_LIM)) begin
                        state_d = BLOCKED;
                    end
                end
                BLOCKED: state_d = BLOCKED;
                default: state_d = RUN;
            endcase
        end
    end

    assign enter_blocked = (state_d == BLOCKED) && (state_q != BLOCKED);

    always_comb begin
        prev_sig_d  = prev_sig_q;
        cnt_d       = cnt_q;
        block_d     = block_q;
        axis_snap_d = axis_snap_q;
        inst_snap_d = inst_snap_q;
        idx_d       = idx_q;
        vld_d       = vld_q;
        if (clear) begin
            prev_sig_d  = '0;
            cnt_d       = '0;
            block_d     = 1'b0;
            axis_snap_d = '0;
            inst_snap_d = '0;
            idx_d       = '0;
            vld_d       = 1'b0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (stall_now) begin
                        cnt_d      = CNT_W'(1);
                        prev_sig_d = sig;
                    end else begin
                        cnt_d = '0;
                    end
                end
                SUSPECT: begin
                    if (!stall_now) begin
                        cnt_d = '0;
                    end else if (!same_sig) begin
                        // A shifting pattern is progress: restart the run on the new pattern.
                        cnt_d      = CNT_W'(1);
                        prev_sig_d = sig;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                BLOCKED: begin
                    if (stall_now && (cnt_q != CNT_MAX)) begin
                        cnt_d = cnt_inc;
                    end
                end
                default: cnt_d = '0;
            endcase
            if (enter_blocked) begin
                block_d     = 1'b1;
                axis_snap_d = axis_block_sigs;
                inst_snap_d = inst_block_sigs;
                idx_d       = enc_idx;
                vld_d       = enc_vld;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prev_sig_q  <= '0;
            cnt_q       <= '0;
            block_q     <= 1'b0;
            axis_snap_q <= '0;
            inst_snap_q <= '0;
            idx_q       <= '0;
            vld_q       <= 1'b0;
        end else begin
            prev_sig_q  <= prev_sig_d;
            cnt_q       <= cnt_d;
            block_q     <= block_d;
            axis_snap_q <= axis_snap_d;
            inst_snap_q <= inst_snap_d;
            idx_q       <= idx_d;
            vld_q       <= vld_d;
        end
    end

    assign block          = block_q;
    assign stall_cnt      = cnt_q;
    assign axis_snap      = axis_snap_q;
    assign inst_snap      = inst_snap_q;
    assign first_axis_idx = idx_q;
    assign first_axis_vld = vld_q;

endmodule

// File: tb/tb_aesl_deadlock_stall_detector.sv
// Bench for aesl_deadlock_stall_detector: directed scenarios plus random traffic against a run-length model.
module tb_aesl_deadlock_stall_detector;

    localparam int unsigned N_AXIS = 2;
    localparam int unsigned N_INST = 1;
    localparam int unsigned STALL  = 4;
    localparam int unsigned CNT_W  = 8;
    localparam int          SAT    = 255;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  axis  = '0;
    logic [0:0]  idle  = '0;
    logic [0:0]  iblk  = '0;
    logic        clear = 1'b0;

    logic        block;
    logic [7:0]  stall_cnt;
    logic [1:0]  axis_snap;
    logic [0:0]  inst_snap;
    logic [0:0]  first_axis_idx;
    logic        first_axis_vld;
    logic [13:0] obs;

    int checks = 0;
    int errors = 0;

    // Reference model: length of the current run of identical stall patterns.
    int          m_run;
    int          m_cnt;
    int          m_idx;
    bit          m_block;
    bit          m_vld;
    logic [2:0]  m_last;
    logic [1:0]  m_asnap;
    logic        m_isnap;

    always #5 clock = ~clock;

    aesl_deadlock_stall_detector #(
        .N_AXIS       (N_AXIS),
        .N_INST       (N_INST),
        .STALL_CYCLES (STALL),
        .CNT_W        (CNT_W)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .axis_block_sigs (axis),
        .inst_idle_sigs  (idle),
        .inst_block_sigs (iblk),
        .clear           (clear),
        .block           (block),
        .stall_cnt       (stall_cnt),
        .axis_snap       (axis_snap),
        .inst_snap       (inst_snap),
        .first_axis_idx  (first_axis_idx),
        .first_axis_vld  (first_axis_vld)
    );

    assign obs = {block, stall_cnt, axis_snap, inst_snap, first_axis_idx, first_axis_vld};

    function automatic logic [13:0] exp_vec();
        return {m_block, 8'(m_cnt), m_asnap, m_isnap, 1'(m_idx), m_vld};
    endfunction

    task automatic model_reset();
        m_run   = 0;
        m_cnt   = 0;
        m_idx   = 0;
        m_block = 0;
        m_vld   = 0;
        m_last  = '0;
        m_asnap = '0;
        m_isnap = 1'b0;
    endtask

    task automatic model_step();
        logic [2:0] sig;
        bit         stall;
        sig   = {iblk, axis};
        stall = (sig != 3'b000) && (idle != 1'b1);
        if (clear) begin
            model_reset();
        end else if (m_block) begin
            if (stall && m_cnt < SAT) m_cnt++;
        end else begin
            if (!stall) m_run = 0;
            else if (m_run > 0 && sig == m_last) m_run++;
            else begin
                m_run  = 1;
                m_last = sig;
            end
            m_cnt = m_run;
            if (m_run == STALL) begin
                m_block = 1;
                m_asnap = axis;
                m_isnap = iblk[0];
                m_vld   = (axis != 2'b00);
                m_idx   = 0;
                for (int i = 1; i >= 0; i--) if (axis[i]) m_idx = i;
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic do_clear();
        axis  = '0;
        iblk  = '0;
        idle  = '0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checks++;
        if (obs !== 14'd0) begin
            errors++;
            $display("FAIL clear_state: got %h exp %h", obs, 14'd0);
        end
    endtask

    task automatic test_reset();
        model_reset();
        axis  = 2'($urandom);
        idle  = 1'($urandom);
        iblk  = 1'($urandom);
        clear = 1'($urandom);
        #3;
        checks++;
        if (obs !== 14'd0) begin
            errors++;
            $display("FAIL reset_async: got %h exp %h", obs, 14'd0);
        end
        @(posedge clock);
        #1;
        checks++;
        if (obs !== 14'd0) begin
            errors++;
            $display("FAIL reset_held: got %h exp %h", obs, 14'd0);
        end
        axis  = '0;
        idle  = '0;
        iblk  = '0;
        clear = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (block !== 1'b0 || stall_cnt !== 8'd0) begin
                errors++;
                $display("FAIL idle_after_reset: got block=%b cnt=%0d exp block=0 cnt=0",
                         block, stall_cnt);
            end
        end
    endtask

    task automatic test_detect();
        axis = 2'b01;
        for (int i = 1; i <= 8; i++) begin
            tick();
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL detect_model[%0d]: got %h exp %h", i, obs, exp_vec());
            end
            checks++;
            if (stall_cnt !== 8'(i) || block !== (i >= 4)) begin
                errors++;
                $display("FAIL detect_edge[%0d]: got block=%b cnt=%0d exp block=%b cnt=%0d",
                         i, block, stall_cnt, (i >= 4), i);
            end
        end
        checks++;
        if (axis_snap !== 2'b01 || first_axis_idx !== 1'b0 || first_axis_vld !== 1'b1) begin
            errors++;
            $display("FAIL detect_snap: got snap=%b idx=%0d vld=%b exp snap=01 idx=0 vld=1",
                     axis_snap, first_axis_idx, first_axis_vld);
        end
        do_clear();
    endtask

    task automatic test_no_block();
        int exp_seq[4] = '{1, 2, 3, 0};
        axis = 2'b10;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) axis = 2'b00;
            tick();
            checks++;
            if (stall_cnt !== 8'(exp_seq[i]) || block !== 1'b0 || obs !== exp_vec()) begin
                errors++;
                $display("FAIL short_stall[%0d]: got block=%b cnt=%0d exp block=0 cnt=%0d",
                         i, block, stall_cnt, exp_seq[i]);
            end
        end
    endtask

    task automatic test_pattern_change();
        axis = 2'b01;
        for (int i = 0; i < 3; i++) tick();
        axis = 2'b10;
        for (int k = 1; k <= 4; k++) begin
            tick();
            checks++;
            if (stall_cnt !== 8'(k) || block !== (k == 4) || obs !== exp_vec()) begin
                errors++;
                $display("FAIL pattern_move[%0d]: got block=%b cnt=%0d exp block=%b cnt=%0d",
                         k, block, stall_cnt, (k == 4), k);
            end
        end
        checks++;
        if (first_axis_idx !== 1'b1 || axis_snap !== 2'b10) begin
            errors++;
            $display("FAIL pattern_idx: got idx=%0d snap=%b exp idx=1 snap=10",
                     first_axis_idx, axis_snap);
        end
        do_clear();
    endtask

    task automatic test_idle();
        axis = 2'b11;
        idle = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (block !== 1'b0 || stall_cnt !== 8'd0) begin
                errors++;
                $display("FAIL idle_suppress[%0d]: got block=%b cnt=%0d exp block=0 cnt=0",
                         i, block, stall_cnt);
            end
        end
        idle = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            checks++;
            if (block !== (k == 4) || obs !== exp_vec()) begin
                errors++;
                $display("FAIL idle_release[%0d]: got %h exp %h", k, obs, exp_vec());
            end
        end
        do_clear();
    endtask

    task automatic test_clear_rearm();
        axis = 2'b01;
        for (int i = 0; i < 4; i++) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checks++;
        if (block !== 1'b0 || stall_cnt !== 8'd0 || axis_snap !== 2'b00 || first_axis_vld !== 1'b0) begin
            errors++;
            $display("FAIL clear_drop: got %h exp %h", obs, 14'd0);
        end
        for (int k = 1; k <= 4; k++) begin
            tick();
            checks++;
            if (block !== (k == 4) || stall_cnt !== 8'(k) || obs !== exp_vec()) begin
                errors++;
                $display("FAIL clear_rearm[%0d]: got block=%b cnt=%0d exp block=%b cnt=%0d",
                         k, block, stall_cnt, (k == 4), k);
            end
        end
        do_clear();
        axis = 2'b01;
        tick();
        tick();
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        checks++;
        if (obs !== 14'd0) begin
            errors++;
            $display("FAIL reset_mid_suspect: got %h exp %h", obs, 14'd0);
        end
        #1;
        axis  = 2'b00;
        reset = 1'b1;
        tick();
        checks++;
        if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL reset_recover: got %h exp %h", obs, exp_vec());
        end
    endtask

    task automatic test_saturate();
        axis = 2'b01;
        for (int i = 0; i < 260; i++) begin
            tick();
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL saturate_model[%0d]: got %h exp %h", i, obs, exp_vec());
            end
        end
        checks++;
        if (stall_cnt !== 8'd255 || block !== 1'b1) begin
            errors++;
            $display("FAIL saturate_end: got block=%b cnt=%0d exp block=1 cnt=255",
                     block, stall_cnt);
        end
        do_clear();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(5) == 0) axis = 2'($urandom);
            if ($urandom_range(7) == 0) iblk = 1'($urandom);
            if ($urandom_range(9) == 0) idle = 1'($urandom);
            clear = ($urandom_range(49) == 0);
            tick();
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL random[%0d]: got %h exp %h", i, obs, exp_vec());
            end
        end
        clear = 1'b0;
    endtask

    initial begin
        test_reset();
        test_detect();
        test_no_block();
        test_pattern_change();
        test_idle();
        test_clear_rearm();
        test_saturate();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
